// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port memory between the instruction-fetch port and the
//   MEM-stage data port. Data requests win ties unless fetch has been passed
//   over STARVE_MAX times in a row, in which case fetch wins the next tie.
//
// Ports
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   if_req/if_addr         fetch request and byte address (held until if_ready)
//   if_rdata/if_ready      fetched instruction, one-cycle completion pulse
//   d_req/d_we/d_addr      data request, store select, byte address
//   d_wdata                store data
//   d_rdata/d_ready        load data, one-cycle completion pulse
//   stall_f/stall_d        pipeline stalls for the fetch and MEM stages
//   m_en/m_we/m_addr       memory strobe, write enable, address (registered)
//   m_wdata                memory write data (registered)
//   m_rdata/m_ack          memory read data and completion
module unified_mem_arbiter #(
    parameter int unsigned N          = 32,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         if_req,
    input  logic [N-1:0] if_addr,
    output logic [N-1:0] if_rdata,
    output logic         if_ready,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [N-1:0] d_addr,
    input  logic [N-1:0] d_wdata,
    output logic [N-1:0] d_rdata,
    output logic         d_ready,
    output logic         stall_f,
    output logic         stall_d,
    output logic         m_en,
    output logic         m_we,
    output logic [N-1:0] m_addr,
    output logic [N-1:0] m_wdata,
    input  logic [N-1:0] m_rdata,
    input  logic         m_ack
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StData  = 2'd2
    } state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e       state_q, state_d;
    logic [3:0]   starve_q, starve_d;
    logic         m_en_q, m_en_d;
    logic         m_we_q, m_we_d;
    logic [N-1:0] m_addr_q, m_addr_d;
    logic [N-1:0] m_wdata_q, m_wdata_d;
    logic [N-1:0] if_rdata_q, if_rdata_d;
    logic [N-1:0] d_rdata_q, d_rdata_d;

    logic if_done;
    logic d_done;
    logic d_load_done;

    assign if_done     = (state_q == StFetch) && m_ack;
    assign d_done      = (state_q == StData) && m_ack;
    assign d_load_done = d_done && !m_we_q;

    // Next-state and grant logic
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        m_en_d     = m_en_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_done ? m_rdata : if_rdata_q;
        d_rdata_d  = d_load_done ? m_rdata : d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (d_req && (!if_req || (starve_q < StarveMax))) begin
                    state_d   = StData;
                    m_en_d    = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    // Only count data wins that actually passed over a fetch
                    if (if_req) begin
                        starve_d = (starve_q >= StarveMax) ? StarveMax : starve_q + 4'd1;
                    end else begin
                        starve_d = 4'd0;
                    end
                end else if (if_req) begin
                    state_d  = StFetch;
                    m_en_d   = 1'b1;
                    m_we_d   = 1'b0;
                    m_addr_d = if_addr;
                    starve_d = 4'd0;
                end else begin
                    starve_d = 4'd0;
                end
            end
            StFetch, StData: begin
                if (m_ack) begin
                    state_d = StIdle;
                    m_en_d  = 1'b0;
                    m_we_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                m_en_d  = 1'b0;
                m_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            starve_q   <= 4'd0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            m_en_q     <= m_en_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Read data is forwarded in the completion cycle, then held from the latch
    assign if_rdata = if_done ? m_rdata : if_rdata_q;
    assign d_rdata  = d_load_done ? m_rdata : d_rdata_q;
    assign if_ready = if_done;
    assign d_ready  = d_done;
    assign stall_f  = if_req & ~if_done;
    assign stall_d  = d_req & ~d_done;
    assign m_en     = m_en_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_unified_mem_arbiter;

    localparam int unsigned N  = 32;
    localparam int unsigned SM = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         if_req;
    logic [N-1:0] if_addr;
    logic [N-1:0] if_rdata;
    logic         if_ready;
    logic         d_req;
    logic         d_we;
    logic [N-1:0] d_addr;
    logic [N-1:0] d_wdata;
    logic [N-1:0] d_rdata;
    logic         d_ready;
    logic         stall_f;
    logic         stall_d;
    logic         m_en;
    logic         m_we;
    logic [N-1:0] m_addr;
    logic [N-1:0] m_wdata;
    logic [N-1:0] m_rdata;
    logic         m_ack;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.N(N), .STARVE_MAX(SM)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .stall_f  (stall_f),
        .stall_d  (stall_d),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one outstanding access at most, plus a count of data
    // wins in a row that passed over a waiting fetch.
    bit          mb;
    bit          mdata;
    bit          mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    int          streak;
    logic [31:0] mif;
    logic [31:0] md;
    bit          last_eif;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mb = 0; mdata = 0; mwe = 0; maddr = '0; mwdata = '0;
        streak = 0; mif = '0; md = '0; last_eif = 0;
    endtask

    // Check all outputs for the current cycle, then advance model across the edge
    task automatic cycle();
        bit eif;
        bit ed;
        #1;
        eif = mb && !mdata && m_ack;
        ed  = mb && mdata && m_ack;
        chk("m_en", 32'(m_en), 32'(mb));
        chk("m_we", 32'(m_we), 32'(mb && mwe));
        if (mb) chk("m_addr", m_addr, maddr);
        if (mb && mdata) chk("m_wdata", m_wdata, mwdata);
        chk("if_ready", 32'(if_ready), 32'(eif));
        chk("d_ready", 32'(d_ready), 32'(ed));
        chk("if_rdata", if_rdata, eif ? m_rdata : mif);
        chk("d_rdata", d_rdata, (ed && !mwe) ? m_rdata : md);
        chk("stall_f", 32'(stall_f), 32'(if_req && !eif));
        chk("stall_d", 32'(stall_d), 32'(d_req && !ed));
        last_eif = eif;
        @(posedge clk);
        if (mb) begin
            if (m_ack) begin
                if (!mdata) mif = m_rdata;
                else if (!mwe) md = m_rdata;
                mb  = 0;
                mwe = 0;
            end
        end else if (d_req && (!if_req || streak < int'(SM))) begin
            mb = 1; mdata = 1; maddr = d_addr; mwdata = d_wdata; mwe = d_we;
            streak = if_req ? streak + 1 : 0;
        end else if (if_req) begin
            mb = 1; mdata = 0; maddr = if_addr; mwe = 0;
            streak = 0;
        end else begin
            streak = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        m_rdata = '0; m_ack = 0;
        model_reset();
        #7;
        chk("rst_m_en", 32'(m_en), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single fetch, acked two cycles after grant
        if_req = 1; if_addr = 32'h10;
        cycle();
        chk("fetch_addr", m_addr, 32'h10);
        chk("fetch_we", 32'(m_we), 32'd0);
        cycle();
        m_ack = 1; m_rdata = 32'h0010_0093;
        #1 chk("fetch_ready", 32'(if_ready), 32'd1);
        cycle();
        m_ack = 0; if_req = 0;
        #1 chk("fetch_hold", if_rdata, 32'h0010_0093);
        cycle();

        // Store then load of the same address
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        cycle();
        chk("store_we", 32'(m_we), 32'd1);
        chk("store_wdata", m_wdata, 32'hDEAD_BEEF);
        m_ack = 1; m_rdata = 32'h1234_5678;
        #1 chk("store_rdata", d_rdata, 32'd0);
        cycle();
        d_req = 0; m_ack = 0;
        cycle();
        d_req = 1; d_we = 0;
        cycle();
        m_ack = 1; m_rdata = 32'hDEAD_BEEF;
        cycle();
        d_req = 0; m_ack = 0;
        #1 chk("load_rdata", d_rdata, 32'hDEAD_BEEF);
        cycle();

        // Contention with one-cycle memory: D D D F D D D F
        if_req = 1; d_req = 1; if_addr = 32'h40; d_addr = 32'h80; m_ack = 1;
        for (int k = 0; k < 16; k++) begin
            cycle();
            chk("cont_en", 32'(m_en), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) chk("cont_addr", m_addr, ((k / 2) % 4 == 3) ? 32'h40 : 32'h80);
        end
        if_req = 0; d_req = 0; m_ack = 0;
        cycle();
        cycle();

        // Starvation counter cleared by an idle grant with no fetch pending
        d_req = 1; m_ack = 1;
        for (int k = 0; k < 14; k++) begin
            if_req = (k == 4) ? 1'b0 : 1'b1;
            cycle();
            if (k >= 6 && k % 2 == 0) chk("clr_addr", m_addr, (k == 12) ? 32'h40 : 32'h80);
        end
        if_req = 0; d_req = 0; m_ack = 0;
        cycle();
        cycle();

        // Spurious ack while idle
        m_ack = 1; m_rdata = 32'hA5A5_5A5A;
        #1 chk("spur_if_ready", 32'(if_ready), 32'd0);
        chk("spur_d_ready", 32'(d_ready), 32'd0);
        cycle();
        cycle();
        m_ack = 0;
        cycle();

        // Fetch request dropped mid-access still completes
        if_req = 1; if_addr = 32'h44;
        cycle();
        if_req = 0;
        cycle();
        m_ack = 1; m_rdata = 32'h0000_0013;
        #1 chk("drop_ready", 32'(if_ready), 32'd1);
        cycle();
        m_ack = 0;
        #1 chk("drop_idle", 32'(m_en), 32'd0);
        cycle();

        // Reset in the middle of a store
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h55;
        cycle();
        chk("pre_rst_en", 32'(m_en), 32'd1);
        m_ack = 1;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_en", 32'(m_en), 32'd0);
        chk("mid_rst_d_ready", 32'(d_ready), 32'd0);
        chk("mid_rst_if_ready", 32'(if_ready), 32'd0);
        model_reset();
        m_ack = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("post_rst_grant", 32'(m_en), 32'd1);
        m_ack = 1;
        cycle();
        d_req = 0; m_ack = 0;
        cycle();

        // Random traffic; requests are mostly held until ready, occasionally dropped
        for (int k = 0; k < 600; k++) begin
            if (if_req) begin
                if (last_eif || $urandom_range(0, 15) == 0) if_req = 1'($urandom_range(0, 1));
            end else begin
                if_req = ($urandom_range(0, 2) != 0);
            end
            if (d_req) begin
                if (d_ready || $urandom_range(0, 15) == 0) d_req = 1'($urandom_range(0, 1));
            end else begin
                d_req = ($urandom_range(0, 2) != 0);
            end
            if_addr = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_we    = 1'($urandom_range(0, 1));
            m_rdata = $urandom;
            m_ack   = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port and its MEM-stage data port.
- Sits between the program counter / instruction-fetch logic and the data-memory stage on one side, and the backing memory on the other.
- Data requests normally win arbitration. A starvation counter guarantees fetch progress.
- Produces per-port stall signals that the pipeline registers and hazard logic consume.

Parameters:
- N, 32, data and address width in bits.
- STARVE_MAX, 3, consecutive data grants allowed while a fetch is pending; the next tie then goes to fetch. Legal range is 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  N  fetch byte address.
- if_rdata  out  N  fetched instruction.
- if_ready  out  1  fetch complete, one-cycle pulse.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  N  data byte address.
- d_wdata  in  N  store data.
- d_rdata  out  N  load data.
- d_ready  out  1  data access complete, one-cycle pulse.
- stall_f  out  1  fetch-side stall.
- stall_d  out  1  MEM-stage stall.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write enable.
- m_addr  out  N  memory address.
- m_wdata  out  N  memory write data.
- m_rdata  in  N  memory read data; valid when m_ack = 1.
- m_ack  in  1  memory completes the current access this cycle.

Behaviour:
- Reset (async, rst = 1):
  - State goes to IDLE and starve_cnt goes to 0.
  - m_en, m_we, m_addr, m_wdata, if_rdata and d_rdata all go to 0.
  - if_ready and d_ready are 0.
- States: IDLE, FETCH, DATA. Transitions are evaluated on the rising edge of clk.
- Arbitration in IDLE:
  - If d_req = 1 and (if_req = 0 or starve_cnt < STARVE_MAX), go to DATA.
  - Otherwise, if if_req = 1, go to FETCH.
  - Otherwise, stay in IDLE.
- On the grant edge, register the winner's address into m_addr, d_wdata into m_wdata, and m_we = d_we (DATA only; 0 for FETCH). Set m_en = 1.
- While in FETCH or DATA:
  - m_en, m_we, m_addr and m_wdata are held stable until m_ack.
  - Requester inputs are not re-sampled.
- Completion cycle (m_ack = 1 in FETCH or DATA):
  - The matching ready is asserted combinationally in the same cycle.
  - if_rdata (FETCH) or d_rdata (DATA load) is driven from m_rdata combinationally in that cycle, and also latched at the edge. It holds that value until the next completion of the same kind.
  - A store does not modify d_rdata.
- Edge after ack:
  - Next state is IDLE; m_en and m_we go to 0.
  - This gives one bubble cycle between accesses; minimum access time is 2 cycles from grant to next grant.
- m_ack in IDLE is ignored: no ready, no latch.
- starve_cnt (4 bits) updates at IDLE grant edges:
  - DATA grant with if_req = 1: increment, saturating at STARVE_MAX.
  - FETCH grant: clear to 0.
  - IDLE with if_req = 0: clear to 0.
- Stalls (combinational): stall_f = if_req & ~if_ready; stall_d = d_req & ~d_ready.
- Simultaneous requests with starve_cnt = STARVE_MAX: fetch wins, then the counter clears.
- Protocol violation: if a request drops before its ready, the access still completes and ready still pulses; the requester must ignore it. Requester inputs changing mid-access have no effect.
- Reset mid-access:
  - The FSM aborts immediately and m_en drops asynchronously.
  - The outcome of a store in flight is undefined in memory; the requester must re-issue.
- Memory with zero-wait behaviour (m_ack high in the first FETCH/DATA cycle) is legal.

Test Plan:
- Reset: assert rst mid-DATA with m_en = 1 -> m_en = 0, both ready = 0, state IDLE immediately. First grant after release is on the first clk edge with a request.
- Single fetch: if_req = 1, if_addr = 0x0000_0010, memory acks 2 cycles after grant with m_rdata = 0x0010_0093 -> m_addr = 0x10, m_we = 0, if_ready pulses 1 cycle, if_rdata = 0x0010_0093 and holds; stall_f = 1 until that cycle.
- Store then load: d_we = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF -> m_we = 1, m_wdata = 0xDEADBEEF; d_rdata unchanged at ack. Then a load of 0x100 with m_rdata = 0xDEADBEEF -> d_rdata = 0xDEADBEEF.
- Contention: if_req and d_req both held high, each access acked in 1 cycle, STARVE_MAX = 3 -> grant order DATA, DATA, DATA, FETCH, DATA, ..., with one IDLE cycle between grants.
- Starvation clear: if_req low for one IDLE cycle after 2 data grants -> starve_cnt = 0. Then 3 further data grants occur before fetch wins the next tie.
- Spurious/early: m_ack pulsed in IDLE -> no ready, rdata unchanged. if_req dropped mid-FETCH -> if_ready still pulses at ack, FSM returns to IDLE.
